// File: rtl/aes256_key_sched_ctrl.sv
// AES-256 key-expansion controller: accepts a 256-bit key and streams rk0..rk14
// over a valid/ready handshake, expanding the 8-word window once per two keys.
module aes256_key_sched_ctrl #(
  parameter int num_rk_p   = 15,
  parameter int rk_width_p = 128
) (
  input  logic                  clk_i,
  input  logic                  reset_n_i,
  input  logic [255:0]          key_i,
  input  logic                  key_v_i,
  output logic                  key_ready_o,
  input  logic                  abort_i,
  output logic [rk_width_p-1:0] rk_o,
  output logic [3:0]            rk_idx_o,
  output logic                  rk_v_o,
  input  logic                  rk_ready_i,
  output logic                  done_o
);

  typedef enum logic [1:0] {IDLE, EMIT_HI, EMIT_LO, EMIT_LAST} state_t;

  localparam logic [3:0] last_lo_idx = 4'(num_rk_p - 2);

  state_t        state_q, state_d;
  logic [255:0]  window_q, window_d;
  logic [7:0]    rcon_q;
  logic [3:0]    idx_q;
  logic          done_q;
  logic [31:0]   sub_rot_q;
  logic          load, adv, expand, fin, clear;

  logic [31:0] w0, w1, w2, w3, w4, w5, w6, w7;
  logic [31:0] n0, n1, n2, n3, n4, n5, n6, n7;
  logic [31:0] sbox_in, sbox_out;

  assign {w0, w1, w2, w3, w4, w5, w6, w7} = window_q;

  // The four S-boxes are shared: in EMIT_HI they compute SubWord(RotWord(W7)),
  // which is held in sub_rot_q; in EMIT_LO they compute SubWord(N3).
  assign sbox_in = (state_q == EMIT_LO) ? n3 : {w7[23:0], w7[31:24]};

  for (genvar b = 0; b < 4; b++) begin : g_sbox
    rom_sbox u_sbox (
      .addr (sbox_in[8*b +: 8]),
      .data (sbox_out[8*b +: 8])
    );
  end

  assign n0 = w0 ^ sub_rot_q ^ {rcon_q, 24'h0};
  assign n1 = w1 ^ n0;
  assign n2 = w2 ^ n1;
  assign n3 = w3 ^ n2;
  assign n4 = w4 ^ sbox_out;
  assign n5 = w5 ^ n4;
  assign n6 = w6 ^ n5;
  assign n7 = w7 ^ n6;
  assign window_d = {n0, n1, n2, n3, n4, n5, n6, n7};

  // NOTE: every output of this block gets a default first so no path leaves a
  // signal unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d     = state_q;
    key_ready_o = 1'b0;
    rk_v_o      = 1'b0;
    rk_o        = '0;
    load        = 1'b0;
    adv         = 1'b0;
    expand      = 1'b0;
    fin         = 1'b0;
    clear       = 1'b0;
    case (state_q)
      IDLE: begin
        key_ready_o = 1'b1;
        if (key_v_i && !abort_i) begin
          load    = 1'b1;
          state_d = EMIT_HI;
        end
      end
      EMIT_HI: begin
        rk_v_o = 1'b1;
        rk_o   = window_q[255:128];
        if (abort_i) begin
          clear   = 1'b1;
          state_d = IDLE;
        end else if (rk_ready_i) begin
          adv     = 1'b1;
          state_d = EMIT_LO;
        end
      end
      EMIT_LO: begin
        rk_v_o = 1'b1;
        rk_o   = window_q[127:0];
        if (abort_i) begin
          clear   = 1'b1;
          state_d = IDLE;
        end else if (rk_ready_i) begin
          adv     = 1'b1;
          expand  = 1'b1;
          state_d = (idx_q == last_lo_idx) ? EMIT_LAST : EMIT_HI;
        end
      end
      EMIT_LAST: begin
        rk_v_o = 1'b1;
        rk_o   = window_q[255:128];
        if (abort_i) begin
          clear   = 1'b1;
          state_d = IDLE;
        end else if (rk_ready_i) begin
          fin     = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) state_q <= IDLE;
    else            state_q <= state_d;
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      window_q  <= '0;
      rcon_q    <= 8'h01;
      idx_q     <= '0;
      done_q    <= 1'b0;
      sub_rot_q <= '0;
    end else begin
      done_q <= fin;
      if (state_q == EMIT_HI) sub_rot_q <= sbox_out;
      if (clear) begin
        window_q <= '0;
        rcon_q   <= '0;
        idx_q    <= '0;
      end else if (load) begin
        window_q <= key_i;
        rcon_q   <= 8'h01;
        idx_q    <= '0;
      end else begin
        if (adv) idx_q <= idx_q + 4'd1;
        if (expand) begin
          window_q <= window_d;
          rcon_q   <= {rcon_q[6:0], 1'b0};
        end
      end
    end
  end

  assign rk_idx_o = idx_q;
  assign done_o   = done_q;

endmodule

// AES forward S-box as a combinational lookup table.
module rom_sbox (
  input  logic [7:0] addr,
  output logic [7:0] data
);
  // NOTE: the table is a constant, so it has no reset and no clock.
  localparam logic [0:255][7:0] lut = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };
  assign data = lut[addr];
endmodule

// File: tb/tb_aes256_key_sched_ctrl.sv
// Randomized self-checking bench: a FIPS-197 word-recurrence model predicts
// every round key, index, valid, ready and done value on every cycle.
module tb_aes256_key_sched_ctrl;

  typedef logic [14:0][127:0] rk_arr_t;

  localparam logic [255:0] key_seq  = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
  localparam logic [255:0] key_fips = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;

  logic         clk_i = 1'b0;
  logic         reset_n_i;
  logic [255:0] key_i;
  logic         key_v_i;
  logic         key_ready_o;
  logic         abort_i;
  logic [127:0] rk_o;
  logic [3:0]   rk_idx_o;
  logic         rk_v_o;
  logic         rk_ready_i;
  logic         done_o;

  int checks = 0;
  int errors = 0;

  aes256_key_sched_ctrl dut (
    .clk_i       (clk_i),
    .reset_n_i   (reset_n_i),
    .key_i       (key_i),
    .key_v_i     (key_v_i),
    .key_ready_o (key_ready_o),
    .abort_i     (abort_i),
    .rk_o        (rk_o),
    .rk_idx_o    (rk_idx_o),
    .rk_v_o      (rk_v_o),
    .rk_ready_i  (rk_ready_i),
    .done_o      (done_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  task automatic timeout(input string name);
    checks++;
    errors++;
    $display("FAIL %s at %0t: wait bound expired", name, $time);
  endtask

  // ---------------- reference model (FIPS-197 key expansion) ----------------
  function automatic logic [7:0] gmul(input logic [7:0] a_in, input logic [7:0] b_in);
    logic [7:0] a = a_in, b = b_in, p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p ^= a;
      a = a[7] ? ({a[6:0], 1'b0} ^ 8'h1b) : {a[6:0], 1'b0};
      b = b >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] inv = 8'h01;
    for (int i = 0; i < 254; i++) inv = gmul(inv, x);
    return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]}
         ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
  endfunction

  function automatic rk_arr_t model_rk(input logic [255:0] key);
    logic [31:0] w [60];
    logic [31:0] t;
    rk_arr_t     rk;
    for (int i = 0; i < 8; i++) w[i] = key[255-32*i -: 32];
    for (int i = 8; i < 60; i++) begin
      t = w[i-1];
      if (i % 8 == 0)      t = sub_word({t[23:0], t[31:24]}) ^ {8'h01 << (i/8 - 1), 24'h0};
      else if (i % 8 == 4) t = sub_word(t);
      w[i] = w[i-8] ^ t;
    end
    for (int r = 0; r < 15; r++) rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    return rk;
  endfunction

  // Cycle-level expectation: busy while a schedule is streaming, idx of the key shown.
  logic       m_busy, m_done;
  logic [3:0] m_idx;
  rk_arr_t    m_rk;

  always @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      m_busy <= 1'b0;
      m_idx  <= '0;
      m_done <= 1'b0;
    end else begin
      m_done <= 1'b0;
      if (m_busy) begin
        if (abort_i) m_busy <= 1'b0;
        else if (rk_ready_i) begin
          if (m_idx == 4'd14) begin
            m_busy <= 1'b0;
            m_done <= 1'b1;
          end else m_idx <= m_idx + 4'd1;
        end
      end else if (key_v_i && !abort_i) begin
        m_busy <= 1'b1;
        m_idx  <= '0;
        m_rk   <= model_rk(key_i);
      end
    end
  end

  logic [127:0] cap [15];
  int           done_cnt = 0;

  always @(negedge clk_i) begin
    if (reset_n_i) begin
      check("key_ready", key_ready_o, !m_busy);
      check("rk_v", rk_v_o, m_busy);
      check("done", done_o, m_done);
      if (m_busy) begin
        check("rk_idx", rk_idx_o, m_idx);
        check("rk", rk_o, m_rk[m_idx]);
        if (rk_ready_i && !abort_i) cap[m_idx] <= rk_o;
      end else begin
        check("rk_idle", rk_o, 128'h0);
      end
      if (done_o) done_cnt <= done_cnt + 1;
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk_i);
    #2;
  endtask

  task automatic send_key(input logic [255:0] k);
    key_i   = k;
    key_v_i = 1'b1;
    tick();
    key_v_i = 1'b0;
  endtask

  task automatic wait_idle(input bit rand_ready, input string name);
    for (int n = 0; n < 300; n++) begin
      if (!m_busy) begin
        rk_ready_i = 1'b1;
        return;
      end
      if (rand_ready) rk_ready_i = 1'($urandom_range(0, 1));
      tick();
    end
    timeout(name);
  endtask

  task automatic wait_idx(input logic [3:0] n, input string name);
    for (int c = 0; c < 100; c++) begin
      if (m_busy && m_idx == n) return;
      tick();
    end
    timeout(name);
  endtask

  function automatic logic [255:0] rand_key();
    logic [255:0] k;
    for (int i = 0; i < 8; i++) k[32*i +: 32] = $urandom;
    return k;
  endfunction

  initial begin
    rk_arr_t pin;
    int      d0;
    reset_n_i  = 1'b0;
    key_i      = '0;
    key_v_i    = 1'b0;
    abort_i    = 1'b0;
    rk_ready_i = 1'b1;
    tick();
    check("reset_rk", rk_o, 128'h0);
    check("reset_idx", rk_idx_o, 4'd0);
    check("reset_rk_v", rk_v_o, 1'b0);
    check("reset_done", done_o, 1'b0);
    tick();
    reset_n_i = 1'b1;
    tick();
    check("reset_key_ready", key_ready_o, 1'b1);

    // Model pinned against published vectors.
    pin = model_rk(key_seq);
    check("model_rk0", pin[0], 128'h000102030405060708090a0b0c0d0e0f);
    check("model_rk2", pin[2], 128'ha573c29fa176c498a97fce93a572c09c);
    check("model_rk14", pin[14], 128'h24fc79ccbf0979e9371ac23c6d68de36);

    // Back-to-back keys at full rate: done must land 16 cycles after acceptance.
    d0 = done_cnt;
    send_key(key_seq);
    for (int c = 1; c < 16; c++) tick();
    check("full_rate_done_timing", done_o, 1'b1);
    check("full_rate_key_ready", key_ready_o, 1'b1);
    tick();
    check("rk0", cap[0], 128'h000102030405060708090a0b0c0d0e0f);
    check("rk1", cap[1], 128'h101112131415161718191a1b1c1d1e1f);
    check("rk2", cap[2], 128'ha573c29fa176c498a97fce93a572c09c);
    check("rk3", cap[3], 128'h1651a8cd0244beda1a5da4c10640bade);
    check("rk14", cap[14], 128'h24fc79ccbf0979e9371ac23c6d68de36);
    check("done_once", 32'(done_cnt - d0), 32'd1);

    // Same key under random back-pressure.
    for (int i = 0; i < 15; i++) cap[i] = '0;
    rk_ready_i = 1'b0;
    send_key(key_seq);
    wait_idle(1'b1, "stall_idle");
    tick();
    check("stall_rk2", cap[2], 128'ha573c29fa176c498a97fce93a572c09c);
    check("stall_rk14", cap[14], 128'h24fc79ccbf0979e9371ac23c6d68de36);

    // key_v_i held through a schedule: the second key loads only at IDLE.
    d0 = done_cnt;
    key_i   = key_seq;
    key_v_i = 1'b1;
    tick();
    key_i = rand_key();
    for (int c = 0; c < 18; c++) tick();
    key_v_i = 1'b0;
    wait_idle(1'b0, "hold_idle");
    tick();
    check("hold_two_schedules", 32'(done_cnt - d0), 32'd2);

    // Abort at idx 6, then a clean rerun.
    d0 = done_cnt;
    send_key(key_seq);
    wait_idx(4'd6, "abort_wait");
    abort_i = 1'b1;
    tick();
    abort_i = 1'b0;
    check("abort_rk_v", rk_v_o, 1'b0);
    check("abort_key_ready", key_ready_o, 1'b1);
    check("abort_done", done_o, 1'b0);
    tick();
    check("abort_no_done", 32'(done_cnt - d0), 32'd0);
    key_i   = key_fips;
    key_v_i = 1'b1;
    abort_i = 1'b1;
    tick();
    key_v_i = 1'b0;
    abort_i = 1'b0;
    check("abort_blocks_load", rk_v_o, 1'b0);
    send_key(key_seq);
    wait_idle(1'b0, "rerun_idle");
    tick();
    check("rerun_rk3", cap[3], 128'h1651a8cd0244beda1a5da4c10640bade);
    check("rerun_rk14", cap[14], 128'h24fc79ccbf0979e9371ac23c6d68de36);

    // Asynchronous reset in the middle of the schedule.
    d0 = done_cnt;
    send_key(key_seq);
    wait_idx(4'd9, "reset_wait");
    #1;
    reset_n_i = 1'b0;
    #1;
    check("midreset_rk", rk_o, 128'h0);
    check("midreset_idx", rk_idx_o, 4'd0);
    check("midreset_rk_v", rk_v_o, 1'b0);
    check("midreset_done", done_o, 1'b0);
    tick();
    tick();
    reset_n_i = 1'b1;
    tick();
    check("midreset_key_ready", key_ready_o, 1'b1);
    check("midreset_no_done", 32'(done_cnt - d0), 32'd0);

    // FIPS-197 vector with back-pressure.
    rk_ready_i = 1'b0;
    send_key(key_fips);
    wait_idle(1'b1, "fips_idle");
    tick();
    check("fips_rk2", cap[2], 128'h9ba354118e6925afa51a8b5f2067fcde);
    check("fips_rk14", cap[14], 128'hfe4890d1e6188d0b046df344706c631e);

    // Random keys, back-pressure, spurious key_v_i and rare aborts.
    for (int k = 0; k < 6; k++) begin
      send_key(rand_key());
      for (int c = 0; c < 40; c++) begin
        rk_ready_i = ($urandom_range(0, 3) != 0);
        abort_i    = ($urandom_range(0, 59) == 0);
        key_v_i    = ($urandom_range(0, 3) == 0);
        key_i      = rand_key();
        tick();
      end
      abort_i = 1'b0;
      key_v_i = 1'b0;
      wait_idle(1'b1, "random_idle");
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

endmodule
